// File: rtl/instr_assembler_pkg.sv
// Shared definitions for the instruction assembler.
//   opcode_e : RV32I major opcodes understood by the packer
//   state_e  : controller states (IDLE / RUN / DRAIN)
package instr_assembler_pkg;

    typedef enum logic [6:0] {
        R_type     = 7'b0110011,
        I_type     = 7'b0010011,
        L_type     = 7'b0000011,
        S_type     = 7'b0100011,
        CB_type    = 7'b1100011,
        LUI_type   = 7'b0110111,
        AUIPC_type = 7'b0010111,
        JAL_type   = 7'b1101111,
        JALR_type  = 7'b1100111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/instr_assembler_if.sv
// Item-in / word-out handshake bundle of the instruction assembler.
//   in_*  : decoded item stream (valid/ready) from the loader
//   out_* : packed instruction + write address (valid/ready) to instruction memory
//   slave  modport : the assembler
//   master modport : the loader / memory side
interface instr_assembler_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_assembler_packer.sv
// instr_packer: combinational RV32I encoder.
//   i_opcode/i_rd/i_rs1/i_rs2/i_funct3/i_funct7/i_imm : item fields
//   o_instr : packed instruction word
//   o_legal : opcode known and immediate representable in its format
module instr_packer
    import instr_assembler_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_legal
);
    logic w_fits12;
    logic w_fits21;

    // Immediate is a correct sign extension of a 12-bit / 21-bit field.
    assign w_fits12 = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
    assign w_fits21 = (i_imm[31:20] == '0) || (i_imm[31:20] == '1);

    always_comb begin
        o_instr = '0;
        o_legal = 1'b0;
        case (i_opcode)
            R_type: begin
                o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_legal = 1'b1;
            end
            I_type, L_type, JALR_type: begin
                o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_legal = w_fits12;
            end
            S_type, CB_type: begin
                o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_legal = w_fits12;
            end
            LUI_type, AUIPC_type: begin
                o_instr = {i_imm[31:12], i_rd, i_opcode};
                o_legal = (i_imm[11:0] == '0);
            end
            JAL_type: begin
                o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_legal = !i_imm[0] && w_fits21;
            end
            default: begin
                o_instr = '0;
                o_legal = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_assembler.sv
// instr_assembler: packs decoded items into RV32I words and streams them to
// instruction memory at incrementing word addresses; illegal items are dropped
// and counted.
//   clk, reset       : clock, synchronous active-high reset
//   start, stop      : run control pulses; base_addr is loaded on start
//   bus (slave)      : item input handshake and word/address output handshake
//   busy             : controller not IDLE
//   err_sticky       : an item was dropped since start
//   err_count        : dropped items (saturating)
//   emit_count       : accepted legal items (saturating)
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [ADDR_W-1:0]  base_addr,
    instr_assembler_if.slave   bus,
    output logic               busy,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   emit_count
);
    state_e              r_state;
    state_e              w_state_next;
    logic                w_in_ready;
    logic                w_accept;
    logic [31:0]         w_instr;
    logic                w_legal;
    logic                r_out_valid;
    logic [31:0]         r_out_instr;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [ADDR_W-1:0]   r_addr_ctr;
    logic                r_err_sticky;
    logic [CNT_W-1:0]    r_err_count;
    logic [CNT_W-1:0]    r_emit_count;

    instr_packer u_packer (
        .i_opcode (bus.in_opcode),
        .i_rd     (bus.in_rd),
        .i_rs1    (bus.in_rs1),
        .i_rs2    (bus.in_rs2),
        .i_funct3 (bus.in_funct3),
        .i_funct7 (bus.in_funct7),
        .i_imm    (bus.in_imm),
        .o_instr  (w_instr),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                w_in_ready = !r_out_valid || bus.out_ready;
                if (stop) w_state_next = DRAIN;
            end
            DRAIN: begin
                // Nothing new is accepted here, so an empty register or a
                // handshake this cycle means the last word has left.
                if (!r_out_valid || bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_addr   <= '0;
            r_addr_ctr   <= '0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            r_emit_count <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_addr_ctr   <= base_addr;
                r_err_sticky <= 1'b0;
                r_err_count  <= '0;
                r_emit_count <= '0;
            end
            if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
            if (w_accept) begin
                if (w_legal) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= w_instr;
                    r_out_addr  <= r_addr_ctr;
                    r_addr_ctr  <= r_addr_ctr + ADDR_W'(4);
                    if (r_emit_count != '1) r_emit_count <= r_emit_count + 1'b1;
                end else begin
                    r_err_sticky <= 1'b1;
                    if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_out_addr;
    assign busy          = (r_state != IDLE);
    assign err_sticky    = r_err_sticky;
    assign err_count     = r_err_count;
    assign emit_count    = r_emit_count;
endmodule

// File: tb/tb_instr_assembler.sv
// Directed testbench for instr_assembler with hand-computed expected words.
module tb_instr_assembler;
    import instr_assembler_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] base_addr;
    logic        busy;
    logic        err_sticky;
    logic [15:0] err_count;
    logic [15:0] emit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_assembler_if #(.ADDR_W(32)) bus ();

    instr_assembler #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .emit_count (emit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic item(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] instr, input logic [31:0] addr);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_instr"}, bus.out_instr, instr);
        chk({tag, "_addr"},  bus.out_addr,  addr);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_addr",  bus.out_addr,  0);
        chk("rst_busy",      busy,          0);
        chk("rst_sticky",    err_sticky,    0);
        chk("rst_err",       err_count,     0);
        chk("rst_emit",      emit_count,    0);
        chk("idle_in_ready", bus.in_ready,  0);

        // First run: single ADDI
        start = 1'b1; base_addr = 32'h100;
        tick();
        start = 1'b0;
        chk("run_busy", busy, 1);
        item(I_type, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        #1 chk("run_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("addi", 32'h00500093, 32'h100);
        chk("addi_emit", emit_count, 1);

        // Stop with empty input: DRAIN then IDLE
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_valid", bus.out_valid, 0);
        tick();
        chk("idle_busy", busy, 0);

        // Second run: back-to-back stream
        start = 1'b1; base_addr = 32'h100;
        tick();
        start = 1'b0;
        chk("restart_emit", emit_count, 0);
        item(S_type, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        tick();
        item(JAL_type, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        chk_out("sw", 32'h0020A423, 32'h100);
        tick();
        chk_out("jal", 32'h001000EF, 32'h104);
        item(LUI_type, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        tick();
        chk_out("lui", 32'h123452B7, 32'h108);
        chk("lui_emit", emit_count, 3);
        item(LUI_type, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        tick();
        chk("lui_bad_err", err_count, 1);
        chk("lui_bad_sticky", err_sticky, 1);
        chk("lui_bad_valid", bus.out_valid, 0);
        chk("lui_bad_emit", emit_count, 3);
        item(I_type, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tick();
        chk("i2048_valid", bus.out_valid, 0);
        item(JAL_type, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        tick();
        chk("jal3_valid", bus.out_valid, 0);
        chk("jal3_err", err_count, 3);
        chk("jal3_sticky", err_sticky, 1);
        item(I_type, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        tick();
        chk_out("addi_m1", 32'hFFF18113, 32'h10C);
        item(I_type, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        tick();
        chk_out("addi_m2048", 32'h80000013, 32'h110);
        item(JAL_type, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        tick();
        chk_out("jal_m4", 32'hFFDFF06F, 32'h114);
        // start while running must be ignored
        item(R_type, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        start = 1'b1; base_addr = 32'h500;
        tick();
        start = 1'b0;
        chk_out("sub", 32'h402081B3, 32'h118);
        chk("sub_emit", emit_count, 7);
        chk("sub_err", err_count, 3);
        item(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        tick();
        chk("badop_err", err_count, 4);
        chk("badop_valid", bus.out_valid, 0);

        // Backpressure
        bus.out_ready = 1'b0;
        item(AUIPC_type, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000);
        #1 chk("bp_ready_empty", bus.in_ready, 1);
        tick();
        chk_out("auipc", 32'h00001097, 32'h11C);
        item(L_type, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'd16);
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_in_ready", bus.in_ready, 0);
            tick();
            chk_out("bp_hold", 32'h00001097, 32'h11C);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("lw", 32'h01012203, 32'h120);
        chk("lw_emit", emit_count, 9);
        tick();
        chk("lw_consumed", bus.out_valid, 0);

        // stop together with the final item under backpressure
        bus.out_ready = 1'b0;
        item(JALR_type, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'd0);
        stop = 1'b1;
        #1 chk("last_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        stop = 1'b0;
        chk_out("jalr", 32'h000280E7, 32'h124);
        chk("jalr_emit", emit_count, 10);
        chk("jalr_busy", busy, 1);
        tick();
        tick();
        chk("drain_hold_busy", busy, 1);
        chk_out("drain_hold", 32'h000280E7, 32'h124);
        chk("drain_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("drain_done_busy", busy, 0);
        chk("drain_done_valid", bus.out_valid, 0);

        // Reset while a word is held
        start = 1'b1; base_addr = 32'h200;
        tick();
        start = 1'b0;
        chk("run3_err", err_count, 0);
        chk("run3_sticky", err_sticky, 0);
        chk("run3_emit", emit_count, 0);
        bus.out_ready = 1'b0;
        item(I_type, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        chk_out("run3_addi", 32'h00500093, 32'h200);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_instr", bus.out_instr, 0);
        chk("mid_rst_addr",  bus.out_addr,  0);
        chk("mid_rst_emit",  emit_count,    0);
        chk("mid_rst_err",   err_count,     0);
        chk("mid_rst_busy",  busy,          0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the datapath's immediate decode: packs opcode, register indices, function fields and a 32-bit sign-extended immediate into one RV32I instruction word.
- Streams instructions to the instruction-memory write port with incrementing word addresses; used by the test/boot loader to build programs in hardware.
- Range-checks each immediate against its format and drops illegal items.
- One output pipeline register with valid/ready handshake, plus an IDLE/RUN/DRAIN controller.

Parameters:
- ADDR_W, 32, width of the output address counter
- CNT_W, 16, width of the emitted-instruction and error counters

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; loads base_addr and enters RUN
- stop  input  1  one-cycle pulse; stops acceptance and drains
- base_addr  input  ADDR_W  first write address (word-aligned)
- in_valid  input  1  input item valid
- in_ready  output  1  block accepts an item this cycle
- in_opcode  input  7  opcode, using the shared opcode defines
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field (R_type only)
- in_imm  input  32  sign-extended immediate (byte offset for branches and jumps)
- out_valid  output  1  out_instr and out_addr are valid
- out_ready  input  1  memory consumes the word
- out_instr  output  32  packed instruction
- out_addr  output  ADDR_W  write address
- busy  output  1  state is not IDLE
- err_sticky  output  1  at least one item dropped since start
- err_count  output  CNT_W  number of dropped items
- emit_count  output  CNT_W  number of accepted instructions

Behaviour:
- Reset: state=IDLE; out_valid=0; out_instr=0; out_addr=0; busy=0; err_sticky=0; err_count=0; emit_count=0. Reset mid-stream discards any held word.
- IDLE: in_ready=0. On start, addr_ctr<=base_addr, clear both counters and err_sticky, go to RUN.
- RUN: in_ready = !out_valid || out_ready. On stop, go to DRAIN; an item accepted in the same cycle as stop is still processed.
- DRAIN: in_ready=0. Go to IDLE in the first cycle with out_valid=0, or in the cycle in which the final word handshakes.
- start outside IDLE is ignored.
- Latency: an item accepted in cycle N appears on out_* in cycle N+1. out_* must hold stable while out_valid && !out_ready. Full throughput is one item per cycle.
- Legal accepted item: out_valid<=1, out_addr<=addr_ctr, addr_ctr+=4 (wraps modulo 2^ADDR_W), emit_count+=1.
- Illegal accepted item: dropped. The output register is unchanged, out_valid is cleared if it is consumed that cycle, addr_ctr is unchanged, err_count+=1, err_sticky<=1.
- Counters saturate at all-ones.
- Packing, with common fields rd[11:7] and opcode[6:0]:
  - R_type: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12].
  - I_type, L_type, JALR_type: imm[11:0] at [31:20], plus rs1 and funct3.
  - S_type and CB_type (same layout): imm[11:5] at [31:25], rs2, rs1, funct3, imm[4:0] at [11:7].
  - LUI_type, AUIPC_type: imm[31:12] at [31:12].
  - JAL_type: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12].
- Legality rules:
  - I, L, JALR, S, CB: in_imm[31:11] all equal.
  - LUI, AUIPC: in_imm[11:0]==0.
  - JAL: in_imm[0]==0 and in_imm[31:20] all equal.
  - Any opcode not in the list above is illegal.

Decomposition:
- Shared defs file holds the opcode defines (R_type, I_type, L_type, S_type, CB_type, LUI_type, AUIPC_type, JAL_type, JALR_type) and the state encodings (IDLE, RUN, DRAIN).
- One combinational sub-module, instr_packer: inputs are the item fields; outputs are instr[31:0] and legal.

Test Plan:
- start with base_addr=0x100, then item I_type rd=1 rs1=0 funct3=0 imm=5 -> next cycle out_instr=0x00500093, out_addr=0x100, emit_count=1.
- S_type rs1=1 rs2=2 funct3=2 imm=8, followed by JAL rd=1 imm=0x800, both back-to-back -> 0x0020A423 @0x100, then 0x001000EF @0x104.
- LUI rd=5 imm=0x12345000 -> 0x123452B7. LUI imm=0x12345001 -> dropped; err_count=1; address not advanced.
- I_type imm=2048 and JAL imm=3 -> both dropped; err_sticky=1; out_valid stays 0.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_* stable. Release -> every queued item emitted in order with no loss or duplication.
- stop asserted in the same cycle as a final accepted item while out_ready=0 -> busy remains 1 until the word handshakes, then state is IDLE. Also assert reset while out_valid=1 -> out_valid=0 on the next cycle and all counters are 0.
